// File: rtl/alu_cmd_issuer.sv
// alu_cmd_issuer: issues 4-bit ALU commands, tracks them through a 2-stage
// in-flight pipeline, and queues the registered ALU result in a response FIFO.
// Latency: command accepted at edge k -> result pushed at edge k+2.
// Backpressure: cmd_ready = (fifo_count + in-flight) < DEPTH, from registered state only.
// Ports: clk/reset (async, active-high); cmd_valid/cmd_ready/cmd_op/cmd_a/cmd_b
//   command in; alu_opcode/alu_a/alu_b to ALU, alu_c result back;
//   rsp_valid/rsp_ready/rsp_data/rsp_op/rsp_err response out; err_count.
// Optional macro ALU_CMD_ISSUER_CHECK_EN compiles the result checker
//   (rsp_err, err_count); without it both are tied to 0.
module alu_cmd_issuer #(
   parameter int DEPTH = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic [1:0] cmd_op,
   input  logic [3:0] cmd_a,
   input  logic [3:0] cmd_b,
   output logic [1:0] alu_opcode,
   output logic [3:0] alu_a,
   output logic [3:0] alu_b,
   input  logic [4:0] alu_c,
   output logic       rsp_valid,
   input  logic       rsp_ready,
   output logic [4:0] rsp_data,
   output logic [1:0] rsp_op,
   output logic       rsp_err,
   output logic [7:0] err_count
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = AW + 1;

   // S1 is the ALU-facing register set itself; S2 trails it by one edge.
   logic [1:0]    alu_opcode_q;
   logic [3:0]    alu_a_q, alu_b_q;
   logic          s1_vld_q, s2_vld_q;
   logic [1:0]    s2_op_q;
   logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic [CW:0]   occupancy;
   logic          accept, push, pop;

   logic [4:0]    dat_mem [DEPTH];
   logic [1:0]    op_mem  [DEPTH];

   assign occupancy = {1'b0, count_q} + (CW+1)'(s1_vld_q) + (CW+1)'(s2_vld_q);
   assign cmd_ready = occupancy < (CW+1)'(DEPTH);
   assign accept    = cmd_valid & cmd_ready;
   assign push      = s2_vld_q;
   assign rsp_valid = count_q != '0;
   assign pop       = rsp_valid & rsp_ready;

   assign alu_opcode = alu_opcode_q;
   assign alu_a      = alu_a_q;
   assign alu_b      = alu_b_q;

   // Head is forced to zero while empty so reset leaves clean outputs
   // without having to clear the storage array.
   assign rsp_data = rsp_valid ? dat_mem[rd_ptr_q] : '0;
   assign rsp_op   = rsp_valid ? op_mem[rd_ptr_q]  : '0;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push) wr_ptr_d = (wr_ptr_q == AW'(DEPTH-1)) ? '0 : wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = (rd_ptr_q == AW'(DEPTH-1)) ? '0 : rd_ptr_q + 1'b1;
      case ({push, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         alu_opcode_q <= '0;
         alu_a_q      <= '0;
         alu_b_q      <= '0;
         s1_vld_q     <= 1'b0;
         s2_vld_q     <= 1'b0;
         s2_op_q      <= '0;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         count_q      <= '0;
      end else begin
         if (accept) begin
            alu_opcode_q <= cmd_op;
            alu_a_q      <= cmd_a;
            alu_b_q      <= cmd_b;
         end
         s1_vld_q <= accept;
         s2_vld_q <= s1_vld_q;
         s2_op_q  <= alu_opcode_q;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         dat_mem[wr_ptr_q] <= alu_c;
         op_mem[wr_ptr_q]  <= s2_op_q;
      end
   end

`ifdef ALU_CMD_ISSUER_CHECK_EN
   logic [3:0] s2_a_q, s2_b_q;
   logic [4:0] sa, sb, exp_c;
   logic       mism;
   logic [7:0] err_cnt_q, err_cnt_d;
   logic       err_mem [DEPTH];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         s2_a_q    <= '0;
         s2_b_q    <= '0;
         err_cnt_q <= '0;
      end else begin
         s2_a_q    <= alu_a_q;
         s2_b_q    <= alu_b_q;
         err_cnt_q <= err_cnt_d;
      end
   end

   always_comb begin
      sa = {s2_a_q[3], s2_a_q};
      sb = {s2_b_q[3], s2_b_q};
      case (s2_op_q)
         2'b00:   exp_c = sa + sb;
         2'b01:   exp_c = sa - sb;
         2'b10:   exp_c = ~sa;
         default: exp_c = {4'b0000, |s2_b_q};
      endcase
      mism      = alu_c != exp_c;
      err_cnt_d = err_cnt_q;
      if (push && mism && err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (push) err_mem[wr_ptr_q] <= mism;
   end

   assign rsp_err   = rsp_valid ? err_mem[rd_ptr_q] : 1'b0;
   assign err_count = err_cnt_q;
`else
   assign rsp_err   = 1'b0;
   assign err_count = 8'h00;
`endif

endmodule

// File: tb/tb_alu_cmd_issuer.sv
// Scoreboard bench for alu_cmd_issuer: a registered ALU model feeds alu_c,
// stimulus pushes hand-computed responses, a negedge monitor pops and compares.
module tb_alu_cmd_issuer;

`ifdef ALU_CMD_ISSUER_CHECK_EN
   localparam bit CHK = 1'b1;
`else
   localparam bit CHK = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       cmd_valid = 1'b0;
   logic       cmd_ready;
   logic [1:0] cmd_op = '0;
   logic [3:0] cmd_a = '0, cmd_b = '0;
   logic [1:0] alu_opcode;
   logic [3:0] alu_a, alu_b;
   logic [4:0] alu_c;
   logic       rsp_valid;
   logic       rsp_ready = 1'b0;
   logic [4:0] rsp_data;
   logic [1:0] rsp_op;
   logic       rsp_err;
   logic [7:0] err_count;

   logic       force_bad = 1'b0;
   int         passed = 0, total = 0;
   logic [7:0] exp_q [$];

   alu_cmd_issuer #(.DEPTH(4)) dut (
      .clk(clk), .reset(reset),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b),
      .alu_opcode(alu_opcode), .alu_a(alu_a), .alu_b(alu_b), .alu_c(alu_c),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_data(rsp_data), .rsp_op(rsp_op), .rsp_err(rsp_err),
      .err_count(err_count)
   );

   always #5 clk = ~clk;

   // External ALU: one registered stage; force_bad corrupts the result by +1.
   always @(posedge clk) begin
      logic [4:0] sa, sb, r;
      sa = {alu_a[3], alu_a};
      sb = {alu_b[3], alu_b};
      case (alu_opcode)
         2'b00:   r = sa + sb;
         2'b01:   r = sa - sb;
         2'b10:   r = ~sa;
         default: r = {4'b0000, |alu_b};
      endcase
      alu_c <= force_bad ? r + 5'd1 : r;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   // Monitor: consumes at the negedge preceding the popping edge.
   always @(negedge clk) begin
      if (!reset && rsp_valid === 1'b1 && rsp_ready) begin
         if (exp_q.size() == 0) chk("unexpected_rsp", {rsp_data, rsp_op, rsp_err}, 32'hFFFF);
         else chk("rsp", {rsp_data, rsp_op, rsp_err}, exp_q.pop_front());
      end
   end

   task automatic send(input logic [1:0] op, input logic [3:0] a, input logic [3:0] b,
                       input logic [4:0] d);
      int n = 0;
      cmd_valid = 1'b1; cmd_op = op; cmd_a = a; cmd_b = b;
      @(negedge clk);
      while (!cmd_ready && n < 100) begin n++; @(negedge clk); end
      chk("send_ready", cmd_ready, 1);
      if (cmd_ready) exp_q.push_back({d, op, CHK & force_bad});
      @(posedge clk); #1;
      cmd_valid = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      rsp_ready = 1'b1;
      while (exp_q.size() != 0 && n < 200) begin n++; @(negedge clk); end
      chk("drain_empty", exp_q.size(), 0);
      @(posedge clk); #1;
      rsp_ready = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout at %0t", $time);
      $fatal(1, "timeout");
   end

   initial begin
      logic [3:0] pat;
      pat = 4'b1011;
      // Reset state
      #3;
      chk("rst_cmd_ready", cmd_ready, 1);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_rsp_fields", {rsp_data, rsp_op, rsp_err}, 0);
      chk("rst_alu", {alu_opcode, alu_a, alu_b}, 0);
      chk("rst_err_count", err_count, 0);
      @(negedge clk); reset = 1'b0;
      @(posedge clk); #1;

      // Latency: add 7+1, no consumer
      send(2'b00, 4'b0111, 4'b0001, 5'b01000);
      chk("alu_loaded", {alu_opcode, alu_a, alu_b}, {2'b00, 4'b0111, 4'b0001});
      @(negedge clk); chk("lat_k_plus0", rsp_valid, 0);
      @(negedge clk); chk("lat_k_plus1", rsp_valid, 0);
      @(negedge clk); chk("lat_k_plus2", rsp_valid, 1);
      chk("lat_data", {rsp_data, rsp_op}, {5'b01000, 2'b00});
      @(negedge clk); chk("hold_data", {rsp_data, rsp_op}, {5'b01000, 2'b00});
      chk("alu_hold", {alu_opcode, alu_a, alu_b}, {2'b00, 4'b0111, 4'b0001});
      @(posedge clk); #1;
      drain();

      // Back-to-back mix
      rsp_ready = 1'b1;
      send(2'b01, 4'b1000, 4'b0111, 5'b10001);
      send(2'b10, 4'b0011, 4'b0101, 5'b11100);
      send(2'b11, 4'b1010, 4'b0000, 5'b00000);
      send(2'b11, 4'b0000, 4'b0100, 5'b00001);
      drain();

      // Full FIFO backpressure, DEPTH=4
      send(2'b00, 4'b0001, 4'b0010, 5'b00011);
      send(2'b01, 4'b0101, 4'b0011, 5'b00010);
      send(2'b10, 4'b1111, 4'b0000, 5'b00000);
      send(2'b11, 4'b0000, 4'b0001, 5'b00001);
      cmd_valid = 1'b1; cmd_op = 2'b00; cmd_a = 4'b1111; cmd_b = 4'b1111;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk); chk("full_not_ready", cmd_ready, 0);
      end
      @(posedge clk); #1; rsp_ready = 1'b1;
      @(negedge clk); chk("pop_cycle_not_ready", cmd_ready, 0);
      @(posedge clk); #1; rsp_ready = 1'b0;
      @(negedge clk); chk("after_pop_ready", cmd_ready, 1);
      if (cmd_ready) exp_q.push_back({5'b11110, 2'b00, 1'b0});
      @(posedge clk); #1; cmd_valid = 1'b0;
      drain();

      // Concurrent push/pop stream with pointer wrap
      fork
         begin
            for (int i = 0; i < 12; i++)
               send(2'b00, 4'(i), 4'b0001, (i < 8) ? 5'(i + 1) : 5'(i + 17));
         end
         begin
            for (int c = 0; c < 30; c++) begin
               rsp_ready = pat[c % 4];
               @(posedge clk); #1;
            end
            rsp_ready = 1'b1;
         end
      join
      drain();

      // Checker behaviour (tied off when the checker is not built)
      force_bad = 1'b1;
      send(2'b00, 4'b0001, 4'b0001, 5'b00011);
      drain();
      chk("err_count_one", err_count, CHK ? 1 : 0);
      force_bad = 1'b0;
      send(2'b00, 4'b0001, 4'b0001, 5'b00010);
      drain();
      chk("err_count_kept", err_count, CHK ? 1 : 0);
      force_bad = 1'b1;
      rsp_ready = 1'b1;
      for (int i = 0; i < 300; i++) send(2'b01, 4'b0011, 4'b0001, 5'b00011);
      drain();
      force_bad = 1'b0;
      chk("err_count_sat", err_count, CHK ? 255 : 0);

      // Reset mid-stream
      send(2'b00, 4'b0010, 4'b0010, 5'b00100);
      send(2'b00, 4'b0011, 4'b0010, 5'b00101);
      send(2'b00, 4'b0100, 4'b0010, 5'b00110);
      reset = 1'b1;
      #1;
      chk("mid_rst_cmd_ready", cmd_ready, 1);
      chk("mid_rst_rsp_valid", rsp_valid, 0);
      chk("mid_rst_alu", {alu_opcode, alu_a, alu_b}, 0);
      chk("mid_rst_err_count", err_count, 0);
      exp_q.delete();
      @(negedge clk); @(negedge clk); reset = 1'b0;
      rsp_ready = 1'b1;
      repeat (6) @(negedge clk);
      chk("no_stale_rsp", rsp_valid, 0);
      @(posedge clk); #1;
      send(2'b01, 4'b0001, 4'b0010, 5'b11111);
      drain();

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/alu_cmd_issuer.md
ALU_CMD_ISSUER -- requirements
Module: alu_cmd_issuer

Interface
REQ-001 SHALL have parameter DEPTH, default 4, response FIFO entries (power of 2, >= 2).
REQ-002 SHALL have ports, one per line:
  clk  input  1  clock, all state updates on rising edge.
  reset  input  1  asynchronous, active-high reset.
  cmd_valid  input  1  command offered.
  cmd_ready  output  1  command accepted when cmd_valid and cmd_ready are both high at an edge.
  cmd_op  input  2  00 add, 01 sub, 10 not A, 11 reduction-OR B.
  cmd_a  input  4  operand A, 2's complement.
  cmd_b  input  4  operand B, 2's complement.
  alu_opcode  output  2  registered opcode driven to the ALU.
  alu_a  output  4  registered operand A driven to the ALU.
  alu_b  output  4  registered operand B driven to the ALU.
  alu_c  input  5  ALU registered result, 2's complement.
  rsp_valid  output  1  response available (FIFO not empty).
  rsp_ready  input  1  response consumed when rsp_valid and rsp_ready are both high at an edge.
  rsp_data  output  5  result at FIFO head.
  rsp_op  output  2  opcode echo at FIFO head.
  rsp_err  output  1  check mismatch flag at FIFO head.
  err_count  output  8  saturating mismatch counter.

Function
REQ-003 SHALL load alu_opcode/alu_a/alu_b from cmd_op/cmd_a/cmd_b at the accepting edge k; they SHALL hold their value when no command is accepted.
REQ-004 SHALL track each accepted command through two in-flight stages (S1 set at edge k, S2 at edge k+1), each carrying opcode and operands.
REQ-005 SHALL sample alu_c into the FIFO at edge k+2 for the command accepted at edge k, so rsp_valid rises 2 cycles after acceptance if the FIFO was empty.
REQ-006 SHALL accept one command per cycle; back-to-back commands SHALL produce back-to-back responses in issue order.
REQ-007 SHALL drive cmd_ready = (fifo_count + S1 valid + S2 valid) < DEPTH, computed from registered state only; a same-cycle pop SHALL NOT raise cmd_ready.
REQ-008 SHALL never overflow the FIFO; push and pop in the same edge SHALL leave fifo_count unchanged.
REQ-009 SHALL present rsp_data/rsp_op/rsp_err from the FIFO head and hold them stable while rsp_valid is high and rsp_ready is low.
REQ-010 SHALL wrap FIFO read and write pointers modulo DEPTH.
REQ-011 SHALL ignore cmd_op/cmd_a/cmd_b when cmd_valid is low, and ignore rsp_ready when rsp_valid is low.

Reset
REQ-012 SHALL, on reset, asynchronously clear alu_opcode, alu_a, alu_b, both stage valids, FIFO pointers, fifo_count and err_count to 0, giving cmd_ready=1, rsp_valid=0, rsp_data=0, rsp_op=0, rsp_err=0.
REQ-013 SHALL discard in-flight and queued results when reset is asserted mid-operation; no response for them SHALL appear after release.

Configuration
REQ-014 SHALL compile the result checker only when macro ALU_CMD_ISSUER_CHECK_EN is defined.
REQ-015 SHALL, with ALU_CMD_ISSUER_CHECK_EN, compute the expected value at stage S2 with 5-bit 2's complement rules: add = sext(A)+sext(B); sub = sext(A)-sext(B); not A = ~sext(A); reduction-OR = {4'b0, |B}.
REQ-016 SHALL, with ALU_CMD_ISSUER_CHECK_EN, store rsp_err = (alu_c != expected) with the entry and increment err_count on each push with a mismatch, saturating at 255.
REQ-017 SHALL, without ALU_CMD_ISSUER_CHECK_EN, tie rsp_err and err_count to 0 and contain no checker logic.

Verification
REQ-018 Reset asserted mid-stream -> immediately cmd_ready=1, rsp_valid=0, alu_* = 0, err_count=0; no stale response after release.
REQ-019 Add A=4'b0111 (7), B=4'b0001 (1) accepted at edge k -> rsp_valid high after edge k+2, rsp_data=5'b01000, rsp_op=00.
REQ-020 Sub A=4'b1000 (-8), B=4'b0111 (7) -> rsp_data=5'b10001 (-15); not A with A=4'b0011 -> 5'b11100; reduction-OR with B=0 -> 5'b00000 and with B=4'b0100 -> 5'b00001; all in order back-to-back.
REQ-021 DEPTH=4, rsp_ready=0, 4 commands accepted back-to-back -> cmd_ready=0 on the 5th cycle and stays 0; one pop -> cmd_ready=1 on the next cycle; the 5th response follows in order.
REQ-022 Simultaneous push and pop with the FIFO at 2 entries for 10 cycles -> fifo_count stays 2, no loss or duplication, pointers wrap cleanly.
REQ-023 With ALU_CMD_ISSUER_CHECK_EN, add 1+1 with the bench forcing alu_c=5'b00011 -> rsp_err=1 and err_count 0->1; a correct result -> rsp_err=0; 300 forced mismatches -> err_count=255.
